floating_round_pipe: RTL
========================

# floating_round_pipe

Pipelined, parametrised rounding stage for the floating-point datapath, the multi-format successor to the combinational multiplier rounder. It takes a raw significand product plus its leading-zero count, extracts fraction, guard, round and sticky bits, and applies one of five IEEE-754 rounding modes. Unlike the combinational rounder, it also:
- propagates the rounding carry into the exponent,
- flags inexact and overflow,
- sits between the significand multiplier and the result packer behind a valid/ready handshake with full-throughput backpressure.

## Interface
Parameters:
- IN_W, 48: width of the raw significand product
- MANT_W, 23: stored fraction width of the output
- CNT_W, 6: width of the leading-zero count
- EXP_W, 8: biased exponent width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream data valid
- in_ready  out  1  this block accepts when in_valid && in_ready
- in_mant  in  IN_W  raw product; hidden bit at position IN_W-1-in_count
- in_count  in  CNT_W  leading-zero count (normalisation shift)
- in_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
- in_sign  in  1  result sign
- in_exp  in  EXP_W  biased exponent, already normalised for in_count
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_mant  out  MANT_W  rounded fraction, hidden bit excluded
- out_exp  out  EXP_W  exponent after rounding carry
- out_inexact  out  1  any of G/R/S set
- out_ovf  out  1  out_exp reached all-ones through rounding carry

## Operation
Hidden bit position: H = IN_W-1-in_count.

Stage 1 (extract):
- Fraction F = bits H-1 down to H-MANT_W.
- Guard G = bit H-MANT_W-1. Round R = bit H-MANT_W-2.
- Sticky S = OR of all bits below H-MANT_W-2.
- Any bit index below 0 reads as 0; S = 0 when its range is empty.
- in_count >= IN_W: F, G, R and S are all 0.
- Register F, G, R, S, mode, sign and exp.

Stage 2 (round):
- inc is decided per mode:
  - RNE: inc = G && (R || S || F[0])
  - RTZ: inc = 0
  - RDN: inc = sign && (G || R || S)
  - RUP: inc = !sign && (G || R || S)
  - RMM: inc = G
- Sum = {1'b0, F} + inc, computed MANT_W+1 bits wide.
- Sum carry set: out_mant = 0 and out_exp = exp + 1. Otherwise out_exp = exp.
- out_ovf = 1 iff the carry occurred and exp + 1 equals 2^EXP_W-1.
- out_inexact = G || R || S.
- in_mode values 101-111: out_mant = 0, out_exp = exp, out_inexact = 0, out_ovf = 0.

Exponent wrap: exp = all-ones with carry wraps modulo 2^EXP_W with out_ovf = 0. Upstream guarantees this case does not occur.

## Timing
- Two register stages; latency 2 cycles from accept to out_valid when out_ready is held high.
- Throughput 1 result/cycle.
- Stage advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready, no storage added)
- While out_valid && !out_ready, all out_* hold stable. No data is lost or duplicated.
- s1 and s2 load only on their advance. A valid bit clears when its data moves on with no replacement.
- Reset (rst high at a clock edge):
  - s1_valid = s2_valid = 0.
  - out_mant, out_exp, out_inexact and out_ovf = 0.
  - in_ready reads 1 in the cycle after reset.
  - Reset mid-stream discards all in-flight data; the first post-reset result comes from the first post-reset accept.
- in_* are sampled only on the accept edge. out_* change only on clock edges.

## Test plan
Defaults IN_W=48, MANT_W=23, EXP_W=8, count=0, out_ready=1 unless stated.
- RNE tie, even LSB: mant=48'h800000_800000, exp=8'h80 -> after 2 cycles out_mant=0, out_exp=8'h80, inexact=1. Same input in RMM -> out_mant=1.
- RNE tie, odd LSB, count=1: mant=48'h400000_C00000 -> RNE out_mant=2. RTZ -> 1. RDN sign=1 -> 2. RUP sign=1 -> 1. RUP sign=0 -> 2.
- Carry and overflow: mant=48'hFFFFFF_FFFFFF, RNE, exp=8'h7F -> out_mant=0, out_exp=8'h80, ovf=0. Same input with exp=8'hFE -> out_exp=8'hFF, ovf=1.
- Exact input and edge cases:
  - mant=48'h800001_000000 -> out_mant=1, inexact=0, in all five modes.
  - count=47 with mant=1 -> out_mant=0, inexact=0.
  - mode 3'b111 -> all outputs 0.
- Backpressure: stream 6 back-to-back inputs with out_ready toggling 1,0,0,1,0,1,... -> outputs match the reference model in order. out_* stay stable while stalled. in_ready=0 exactly when both stages are full and out_ready=0.
- Reset mid-stream: assert rst for 1 cycle with both stages valid -> next cycle out_valid=0, all outputs 0, in_ready=1. The next accept produces out_valid 2 cycles later.

Source files
------------

// File: rtl/floating_round_pipe.sv
// floating_round_pipe: two-stage IEEE-754 significand rounder with valid/ready handshake.
// Stage 1 extracts fraction/G/R/S from the normalised product, stage 2 rounds and carries into the exponent.
module floating_round_pipe #(
    parameter int IN_W   = 48,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 6,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_mant,
    input  logic [CNT_W-1:0]  in_count,
    input  logic [2:0]        in_mode,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_inexact,
    output logic              out_ovf
);
    localparam int EXT_W = IN_W + MANT_W + 3;
    localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;

    logic [IN_W-1:0]   w_shift;
    logic [EXT_W-1:0]  w_ext;
    logic [MANT_W-1:0] w_f;
    logic              w_g, w_r, w_s;
    logic              w_unused;
    logic              w_s1_adv, w_s2_adv;
    logic              w_mode_ok, w_any, w_inc, w_carry, w_ovf;
    logic [MANT_W:0]   w_sum;
    logic [EXP_W-1:0]  w_exp_nx;

    logic              r_s1_valid, r_s2_valid;
    logic [MANT_W-1:0] r_s1_f;
    logic              r_s1_g, r_s1_r, r_s1_s, r_s1_sign;
    logic [2:0]        r_s1_mode;
    logic [EXP_W-1:0]  r_s1_exp;
    logic [MANT_W-1:0] r_mant;
    logic [EXP_W-1:0]  r_exp;
    logic              r_inexact, r_ovf;

    // Shifting left puts the hidden bit at IN_W-1; the zero pad makes bits below index 0 read as 0.
    assign w_shift  = in_mant << in_count;
    assign w_ext    = {w_shift, {(MANT_W + 3){1'b0}}};
    assign w_f      = w_ext[EXT_W-2 -: MANT_W];
    assign w_g      = w_ext[IN_W+1];
    assign w_r      = w_ext[IN_W];
    assign w_s      = |w_ext[IN_W-1:0];
    assign w_unused = w_ext[EXT_W-1];

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;

    assign w_mode_ok = r_s1_mode <= RMM;
    assign w_any     = r_s1_g || r_s1_r || r_s1_s;

    always_comb begin
        w_inc = (r_s1_mode == RNE) ? (r_s1_g && (r_s1_r || r_s1_s || r_s1_f[0])) :
                (r_s1_mode == RTZ) ? 1'b0 :
                (r_s1_mode == RDN) ? (r_s1_sign && w_any) :
                (r_s1_mode == RUP) ? (!r_s1_sign && w_any) :
                (r_s1_mode == RMM) ? r_s1_g : 1'b0;
        w_sum    = {1'b0, r_s1_f} + (MANT_W + 1)'(w_inc);
        w_carry  = w_sum[MANT_W];
        w_exp_nx = r_s1_exp + EXP_W'(w_carry);
        w_ovf    = w_carry && (w_exp_nx == {EXP_W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            r_s1_f    <= w_f;
            r_s1_g    <= w_g;
            r_s1_r    <= w_r;
            r_s1_s    <= w_s;
            r_s1_mode <= in_mode;
            r_s1_sign <= in_sign;
            r_s1_exp  <= in_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_mant     <= '0;
            r_exp      <= '0;
            r_inexact  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_s1_adv) r_s1_valid <= in_valid;
            if (w_s2_adv) r_s2_valid <= r_s1_valid;
            if (w_s2_adv && r_s1_valid) begin
                r_mant    <= w_mode_ok ? w_sum[MANT_W-1:0] : '0;
                r_exp     <= w_mode_ok ? w_exp_nx : r_s1_exp;
                r_inexact <= w_mode_ok && w_any;
                r_ovf     <= w_mode_ok && w_ovf;
            end
        end
    end

    assign out_mant    = r_mant;
    assign out_exp     = r_exp;
    assign out_inexact = r_inexact;
    assign out_ovf     = r_ovf;
endmodule
